// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised Moore sequence detector.
//  - clog2: state-register width helper (never returns less than 1)
//  - DEF_*: default pattern length, reset pattern and counter width
//  - S0 / MATCH: state encoding, where the state is the matched prefix length
package seq_det_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) res = i + 1;
      end
      return (res == 0) ? 1 : res;
   endfunction

   localparam int unsigned DEF_PAT_W = 4;
   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;
   localparam int unsigned DEF_CNT_W = 8;

   // State value equals the matched prefix length; MATCH is the full pattern length.
   localparam int unsigned S0 = 0;
   localparam int unsigned MATCH = DEF_PAT_W;

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state function of the pattern detector.
//  cur_state_i  : current matched prefix length (0..PAT_W)
//  pattern_i    : active pattern, MSB is the first bit on the wire
//  bit_i        : newly sampled serial bit
//  overlap_en_i : 0 = a full match restarts from an empty prefix
//  next_state_o : longest prefix of the pattern that is a suffix of (prefix(cur) & bit_i)
module seq_det_next_state #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned ST_W  = 3
) (
   input  logic [ST_W-1:0]  cur_state_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic             bit_i,
   input  logic             overlap_en_i,
   output logic [ST_W-1:0]  next_state_o
);

   logic [PAT_W:0] pat_ext;
   logic [PAT_W:0] hist;
   logic [PAT_W:0] mask;
   logic [PAT_W:0] pfx;
   int unsigned    cur_len;

   assign pat_ext = {1'b0, pattern_i};

   always_comb begin
      cur_len = 32'(cur_state_i);
      if (!overlap_en_i && (cur_len == PAT_W)) cur_len = 0;

      // Bits seen so far (the current prefix) with the new bit appended, right-aligned.
      hist = ((pat_ext >> (PAT_W - cur_len)) << 1) | {{PAT_W{1'b0}}, bit_i};

      next_state_o = '0;
      mask         = '0;
      pfx          = '0;
      // Ascending k so the longest matching prefix wins.
      for (int unsigned k = 1; k <= PAT_W; k++) begin
         mask = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - k);
         pfx  = pat_ext >> (PAT_W - k);
         // k may not exceed the history length, else leading zeros could alias.
         if ((k <= cur_len + 1) && ((hist & mask) == pfx)) next_state_o = ST_W'(k);
      end
   end

endmodule

// File: rtl/seq_detector_moore_param.sv
// Moore serial pattern detector with a programmable pattern, overlap control,
// input qualifier and saturating match counter.
//  clock, reset  : rising-edge clock, asynchronous active-high reset
//  sequence_in   : serial bit, sampled only when in_valid=1
//  pat_load      : load pat_in and restart from S0 (wins over in_valid)
//  overlap_en    : 1 = overlapping matches counted
//  clear_cnt     : synchronous clear of match_count / count_sat
//  detector_out  : high while in the MATCH state
//  match_count   : saturating count of MATCH-state entries
//  count_sat     : sticky flag, match_count reached all-ones
module seq_detector_moore_param
   import seq_det_pkg::*;
#(
   parameter int unsigned          PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0]     PATTERN = DEF_PATTERN,
   parameter int unsigned          CNT_W   = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sequence_in,
   input  logic             in_valid,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap_en,
   input  logic             clear_cnt,
   output logic             detector_out,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int unsigned StW = clog2(PAT_W + 1);
   localparam logic [StW-1:0] StS0    = StW'(S0);
   localparam logic [StW-1:0] StMatch = StW'(PAT_W);

   logic [StW-1:0]   state_q, state_d, nxt_state;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             match_entry;

   seq_det_next_state #(
      .PAT_W (PAT_W),
      .ST_W  (StW)
   ) u_next_state (
      .cur_state_i  (state_q),
      .pattern_i    (pat_q),
      .bit_i        (sequence_in),
      .overlap_en_i (overlap_en),
      .next_state_o (nxt_state)
   );

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      match_entry = 1'b0;

      if (pat_load) begin
         // The bit presented with a load is discarded.
         pat_d   = pat_in;
         state_d = StS0;
      end else if (in_valid) begin
         state_d     = nxt_state;
         match_entry = (nxt_state == StMatch);
      end

      if (clear_cnt) begin
         cnt_d = match_entry ? CNT_W'(1) : '0;
         sat_d = 1'b0;
      end else if (match_entry && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
         if (&cnt_d) sat_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StS0;
         pat_q   <= PATTERN;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign detector_out = (state_q == StMatch);
   assign match_count  = cnt_q;
   assign count_sat    = sat_q;

endmodule

// File: tb/tb_seq_detector_moore_param.sv
module tb_seq_detector_moore_param;

   logic       clock = 1'b0;
   logic       reset;
   logic       sequence_in, in_valid, pat_load, overlap_en, clear_cnt;
   logic [3:0] pat_in;
   logic       detector_out;
   logic [7:0] match_count;
   logic       count_sat;

   // Second instance: 2-bit counter, pattern 1111.
   logic       s2_in, s2_valid, s2_load, s2_ovl, s2_clr;
   logic [3:0] s2_pat;
   logic       d2_out;
   logic [1:0] c2_count;
   logic       c2_sat;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   seq_detector_moore_param dut (
      .clock        (clock),
      .reset        (reset),
      .sequence_in  (sequence_in),
      .in_valid     (in_valid),
      .pat_load     (pat_load),
      .pat_in       (pat_in),
      .overlap_en   (overlap_en),
      .clear_cnt    (clear_cnt),
      .detector_out (detector_out),
      .match_count  (match_count),
      .count_sat    (count_sat)
   );

   seq_detector_moore_param #(
      .PAT_W   (4),
      .PATTERN (4'b1111),
      .CNT_W   (2)
   ) dut2 (
      .clock        (clock),
      .reset        (reset),
      .sequence_in  (s2_in),
      .in_valid     (s2_valid),
      .pat_load     (s2_load),
      .pat_in       (s2_pat),
      .overlap_en   (s2_ovl),
      .clear_cnt    (s2_clr),
      .detector_out (d2_out),
      .match_count  (c2_count),
      .count_sat    (c2_sat)
   );

   // Reference model: a match is the last 4 bits received since the last restart
   // equalling the pattern; non-overlap mode forgets history after a match.
   bit         hist[$];
   logic [3:0] m_pat;
   bit         m_match;
   int         m_cnt;
   bit         m_sat;

   task automatic model_reset();
      hist.delete();
      m_pat   = 4'b1011;
      m_match = 1'b0;
      m_cnt   = 0;
      m_sat   = 1'b0;
   endtask

   task automatic model_step(input logic b, input logic v, input logic ld,
                             input logic [3:0] pin, input logic ovl, input logic clr);
      bit         entry = 1'b0;
      logic [3:0] win;
      if (ld) begin
         m_pat   = pin;
         hist.delete();
         m_match = 1'b0;
      end else if (v) begin
         if (m_match && !ovl) hist.delete();
         hist.push_back(b);
         if (hist.size() > 4) void'(hist.pop_front());
         m_match = 1'b0;
         if (hist.size() == 4) begin
            win     = {hist[0], hist[1], hist[2], hist[3]};
            m_match = (win == m_pat);
         end
         entry = m_match;
      end
      if (clr) begin
         m_cnt = entry ? 1 : 0;
         m_sat = 1'b0;
      end else if (entry && m_cnt < 255) begin
         m_cnt++;
         if (m_cnt == 255) m_sat = 1'b1;
      end
   endtask

   task automatic drive(input logic b, input logic v, input logic ld,
                        input logic [3:0] pin, input logic ovl, input logic clr);
      sequence_in = b;
      in_valid    = v;
      pat_load    = ld;
      pat_in      = pin;
      overlap_en  = ovl;
      clear_cnt   = clr;
      @(posedge clock);
      #1;
      model_step(b, v, ld, pin, ovl, clr);
      pat_load  = 1'b0;
      clear_cnt = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sequence_in = 0; in_valid = 0; pat_load = 0; pat_in = 0; overlap_en = 1; clear_cnt = 0;
      s2_in = 0; s2_valid = 0; s2_load = 0; s2_pat = 0; s2_ovl = 1; s2_clr = 0;
      #1;
      n_checks++;
      if ({detector_out, match_count, count_sat} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset dut: got det=%b cnt=%0d sat=%b, expected all 0",
                  detector_out, match_count, count_sat);
      end
      n_checks++;
      if ({d2_out, c2_count, c2_sat} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset dut2: got det=%b cnt=%0d sat=%b, expected all 0",
                  d2_out, c2_count, c2_sat);
      end
      #3;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic run_stream(input string name, input logic [6:0] s, input logic ovl,
                             input logic [6:0] exp_det, input int exp_cnt);
      for (int i = 0; i < 7; i++) begin
         drive(s[6-i], 1'b1, 1'b0, 4'b0, ovl, 1'b0);
         n_checks++;
         if ({detector_out, match_count, count_sat} !== {m_match, 8'(m_cnt), m_sat} ||
             detector_out !== exp_det[6-i]) begin
            n_fail++;
            $display("FAIL %s bit%0d: got det=%b cnt=%0d sat=%b, expected det=%b cnt=%0d sat=%b",
                     name, i, detector_out, match_count, count_sat, exp_det[6-i], m_cnt, m_sat);
         end
      end
      n_checks++;
      if (match_count !== 8'(exp_cnt)) begin
         n_fail++;
         $display("FAIL %s final count: got %0d, expected %0d", name, match_count, exp_cnt);
      end
   endtask

   task automatic test_overlap();
      apply_reset();
      run_stream("overlap", 7'b1011011, 1'b1, 7'b0001001, 2);
   endtask

   task automatic test_no_overlap();
      apply_reset();
      run_stream("no_overlap", 7'b1011011, 1'b0, 7'b0001000, 1);
   endtask

   task automatic test_stall();
      logic [3:0] bits = 4'b1011;
      logic [3:0] vld  = 4'b1110;
      logic [6:0] s    = 7'b1010001;
      logic [6:0] v    = 7'b1110001;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         // Junk bits during the stall must be ignored.
         drive(v[6-i] ? s[6-i] : 1'($urandom_range(1)), v[6-i], 1'b0, 4'b0, 1'b1, 1'b0);
         n_checks++;
         if ({detector_out, match_count, count_sat} !== {m_match, 8'(m_cnt), m_sat} ||
             detector_out !== (i == 6)) begin
            n_fail++;
            $display("FAIL stall step%0d: got det=%b cnt=%0d sat=%b, expected det=%b cnt=%0d",
                     i, detector_out, match_count, count_sat, (i == 6), m_cnt);
         end
      end
      n_checks++;
      if (match_count !== 8'd1 || bits[0] !== 1'b1 || vld[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL stall count: got %0d, expected 1", match_count);
      end
   endtask

   task automatic test_pat_load();
      apply_reset();
      drive(1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
      // This 1 would complete 1011 but must be discarded by the load.
      drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
      n_checks++;
      if (detector_out !== 1'b0 || match_count !== 8'd0) begin
         n_fail++;
         $display("FAIL pat_load edge: got det=%b cnt=%0d, expected det=0 cnt=0",
                  detector_out, match_count);
      end
      run_stream("pat_load", 7'b0110110, 1'b1, 7'b0001001, 2);
   endtask

   task automatic test_saturate();
      logic [6:0] exp_det = 7'b0001111;
      logic [6:0] exp_sat = 7'b0000011;
      int         exp_c[7] = '{0, 0, 0, 1, 2, 3, 3};
      int         exp_t[3] = '{1, 2, 3};
      apply_reset();
      s2_in    = 1'b1;
      s2_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clock);
         #1;
         n_checks++;
         if (d2_out !== exp_det[6-i] || c2_count !== 2'(exp_c[i]) || c2_sat !== exp_sat[6-i]) begin
            n_fail++;
            $display("FAIL saturate bit%0d: got det=%b cnt=%0d sat=%b, expected det=%b cnt=%0d sat=%b",
                     i, d2_out, c2_count, c2_sat, exp_det[6-i], exp_c[i], exp_sat[6-i]);
         end
      end
      s2_valid = 1'b0;
      s2_clr   = 1'b1;
      @(posedge clock);
      #1;
      n_checks++;
      if (c2_count !== 2'd0 || c2_sat !== 1'b0 || d2_out !== 1'b1) begin
         n_fail++;
         $display("FAIL clear: got det=%b cnt=%0d sat=%b, expected det=1 cnt=0 sat=0",
                  d2_out, c2_count, c2_sat);
      end
      // Clear coinciding with a match entry leaves a count of one.
      s2_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         s2_clr = 1'b0;
         n_checks++;
         if (c2_count !== 2'(exp_t[i]) || c2_sat !== (i == 2)) begin
            n_fail++;
            $display("FAIL clear_match step%0d: got cnt=%0d sat=%b, expected cnt=%0d sat=%b",
                     i, c2_count, c2_sat, exp_t[i], (i == 2));
         end
      end
      s2_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [5:0] s = 6'b101101;
      logic [3:0] t = 4'b1011;
      apply_reset();
      for (int i = 0; i < 6; i++) drive(s[5-i], 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
      n_checks++;
      if (match_count !== 8'd1 || detector_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid pre: got det=%b cnt=%0d, expected det=0 cnt=1",
                  detector_out, match_count);
      end
      reset = 1'b1;
      #2;
      n_checks++;
      if ({detector_out, match_count, count_sat} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_mid async: got det=%b cnt=%0d sat=%b, expected all 0",
                  detector_out, match_count, count_sat);
      end
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
      n_checks++;
      if (detector_out !== 1'b0 || match_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid lone1: got det=%b cnt=%0d, expected det=0 cnt=0",
                  detector_out, match_count);
      end
      for (int i = 0; i < 4; i++) begin
         drive(t[3-i], 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
         n_checks++;
         if (detector_out !== m_match || detector_out !== (i == 3)) begin
            n_fail++;
            $display("FAIL reset_mid tail%0d: got det=%b, expected det=%b",
                     i, detector_out, (i == 3));
         end
      end
   endtask

   task automatic test_random();
      logic       b, v, ld, ovl, clr;
      logic [3:0] pin;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         b   = 1'($urandom_range(1));
         v   = ($urandom_range(9) < 8);
         ld  = ($urandom_range(39) == 0);
         pin = 4'($urandom_range(15));
         ovl = ($urandom_range(3) != 0);
         clr = ($urandom_range(39) == 0);
         drive(b, v, ld, pin, ovl, clr);
         n_checks++;
         if ({detector_out, match_count, count_sat} !== {m_match, 8'(m_cnt), m_sat}) begin
            n_fail++;
            $display("FAIL random cyc%0d: got det=%b cnt=%0d sat=%b, expected det=%b cnt=%0d sat=%b",
                     i, detector_out, match_count, count_sat, m_match, m_cnt, m_sat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_no_overlap();
      test_stall();
      test_pat_load();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
